// File: rtl/gray_step_if.sv
// gray_step_if -- streaming handshake bundle between the upstream Gray source,
// the gray_step_checker and its downstream consumer.
//
// Handshake: a beat moves across a side on a rising clock edge when valid and
// ready are both 1 on that side. The producer holds valid (and its data) until
// the beat is taken. Ready may depend combinationally on the consumer's state
// but never on the producer's valid.
//
// Signals:
//   gray_in   [3:0]  Gray-coded digit from the upstream stage
//   in_valid         gray_in is valid this cycle
//   in_ready         checker accepts a beat this cycle
//   bcd_out   [3:0]  decoded BCD digit
//   out_valid        output beat present
//   out_ready        downstream accepts the output beat
//   step_err         beat was not a legal single-step Gray transition
//   range_err        decoded value is above 9
//   (step_err/range_err are meaningful only while out_valid is 1)
//
// Modports: master = upstream/downstream side (testbench), slave = checker.
interface gray_step_if;
    logic [3:0] gray_in;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] bcd_out;
    logic       out_valid;
    logic       out_ready;
    logic       step_err;
    logic       range_err;

    modport master (
        output gray_in, in_valid, out_ready,
        input  in_ready, bcd_out, out_valid, step_err, range_err
    );

    modport slave (
        input  gray_in, in_valid, out_ready,
        output in_ready, bcd_out, out_valid, step_err, range_err
    );
endinterface

// File: rtl/gray_step_checker.sv
// gray_step_checker -- decodes a stream of Gray-coded BCD digits back to BCD,
// checks that consecutive codes differ by one bit (the 9<->0 wrap, 1101<->0000,
// counts as legal), flags codes that decode above 9, and keeps a sticky fault
// state plus a saturating error count.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bus        gray_step_if.slave: gray_in/in_valid/in_ready input side,
//              bcd_out/out_valid/out_ready/step_err/range_err output side
//   clear_err  single-cycle pulse: back to IDLE and zero the error count
//   fault      1 exactly while the FSM is in FAULT
//   err_count  errored beats seen, saturating at 255
//   state_dbg  current FSM state (0 IDLE, 1 TRACK, 2 FAULT)
//
// Build option: define GRAY_HOLD_ALLOW_EN to accept a repeated code
// (Hamming distance 0) without raising step_err.
module gray_step_checker (
    input  logic            clk,
    input  logic            rst,
    gray_step_if.slave      bus,
    input  logic            clear_err,
    output logic            fault,
    output logic [7:0]      err_count,
    output logic [1:0]      state_dbg
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [3:0] prev_code;
    logic [3:0] dec;
    logic [3:0] diff;
    logic       accept;
    logic       first_code;
    logic       step_ok;
    logic       step_chk;
    logic       range_chk;
    logic       beat_err;

    // Single output register; a pop frees the slot in the same cycle.
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // Gray to binary: each bit is the XOR of all Gray bits at or above it.
    assign dec = {bus.gray_in[3],
                  ^bus.gray_in[3:2],
                  ^bus.gray_in[3:1],
                  ^bus.gray_in[3:0]};

    assign range_chk = (dec > 4'd9);
    assign diff      = bus.gray_in ^ prev_code;

    // A beat taken together with clear_err starts a fresh sequence.
    assign first_code = clear_err || (state == IDLE);

`ifdef GRAY_HOLD_ALLOW_EN
    assign step_ok = (diff == 4'b0001) || (diff == 4'b0010) ||
                     (diff == 4'b0100) || (diff == 4'b1000) ||
                     (diff == 4'b0000) ||
                     (prev_code == 4'b1101 && bus.gray_in == 4'b0000) ||
                     (prev_code == 4'b0000 && bus.gray_in == 4'b1101);
`else
    assign step_ok = (diff == 4'b0001) || (diff == 4'b0010) ||
                     (diff == 4'b0100) || (diff == 4'b1000) ||
                     (prev_code == 4'b1101 && bus.gray_in == 4'b0000) ||
                     (prev_code == 4'b0000 && bus.gray_in == 4'b1101);
`endif

    assign step_chk = !first_code && !step_ok;
    assign beat_err = step_chk || range_chk;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // FSM: next state
    always_comb begin
        state_n = state;
        if (clear_err) begin
            if (accept) begin
                state_n = range_chk ? FAULT : TRACK;
            end else begin
                state_n = IDLE;
            end
        end else if (accept) begin
            case (state)
                IDLE:    state_n = range_chk ? FAULT : TRACK;
                TRACK:   state_n = beat_err ? FAULT : TRACK;
                default: state_n = FAULT;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        fault     = (state == FAULT);
        state_dbg = state;
    end

    // Output beat register and previous-code store. Erroneous beats still
    // become the reference for the next step check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.bcd_out   <= 4'b0000;
            bus.step_err  <= 1'b0;
            bus.range_err <= 1'b0;
            prev_code     <= 4'b0000;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.bcd_out   <= dec;
            bus.step_err  <= step_chk;
            bus.range_err <= range_chk;
            prev_code     <= bus.gray_in;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    // Error counter; clear wins, but a beat taken with the clear still counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= 8'd0;
        end else if (clear_err) begin
            err_count <= {7'd0, accept && range_chk};
        end else if (accept && beat_err && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_gray_step_checker.sv
// tb_gray_step_checker -- directed vectors with hand-computed expectations
// for gray_step_checker.
module tb_gray_step_checker;
    logic       clk;
    logic       rst;
    logic       clear_err;
    logic       fault;
    logic [7:0] err_count;
    logic [1:0] state_dbg;

    int tests_run;
    int tests_failed;

    logic [3:0] exp_q[$];
    logic [3:0] exp_bcd;

    gray_step_if bus_if ();

    gray_step_checker dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if.slave),
        .clear_err (clear_err),
        .fault     (fault),
        .err_count (err_count),
        .state_dbg (state_dbg)
    );

    // Clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        clear_err        = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.gray_in   = 4'b0000;
        bus_if.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Present one beat with out_ready high; sample 1 time unit after the edge.
    task automatic beat(input logic [3:0] g);
        bus_if.in_valid = 1'b1;
        bus_if.gray_in  = g;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
    endtask

    // flags packs {step_err, range_err, fault}
    task automatic check_out(input string tag, input logic [3:0] bcd,
                             input logic [2:0] flags, input logic [7:0] cnt);
        check_eq({tag, ".valid"}, bus_if.out_valid, 1'b1);
        check_eq({tag, ".bcd"}, bus_if.bcd_out, bcd);
        check_eq({tag, ".flags"}, {bus_if.step_err, bus_if.range_err, fault}, flags);
        check_eq({tag, ".cnt"}, err_count, cnt);
    endtask

    logic [3:0] stream [10];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        stream = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
                   4'b0111, 4'b0101, 4'b0100, 4'b1100, 4'b1101};

        // Reset state
        do_reset();
        check_eq("rst.out_valid", bus_if.out_valid, 1'b0);
        check_eq("rst.bcd", bus_if.bcd_out, 4'b0000);
        check_eq("rst.flags", {bus_if.step_err, bus_if.range_err, fault}, 3'b000);
        check_eq("rst.cnt", err_count, 8'd0);
        check_eq("rst.state", state_dbg, 2'd0);
        check_eq("rst.in_ready", bus_if.in_ready, 1'b1);

        // Clean 0..9 stream
        for (int i = 0; i < 10; i++) exp_q.push_back(4'(i));
        for (int i = 0; i < 10; i++) begin
            beat(stream[i]);
            exp_bcd = exp_q.pop_front();
            check_out($sformatf("stream%0d", i), exp_bcd, 3'b000, 8'd0);
        end
        check_eq("stream.state", state_dbg, 2'd1);

        // 9 -> 0 wrap is legal, then a two-bit jump faults
        beat(4'b0000);
        check_out("wrap90", 4'd0, 3'b000, 8'd0);
        beat(4'b0011);
        check_out("jump", 4'd2, 3'b101, 8'd1);
        check_eq("jump.state", state_dbg, 2'd2);

        // clear_err alone returns to IDLE
        clear_err = 1'b1;
        @(posedge clk);
        #1;
        clear_err = 1'b0;
        check_eq("clr.fault", fault, 1'b0);
        check_eq("clr.cnt", err_count, 8'd0);
        check_eq("clr.state", state_dbg, 2'd0);

        // 0 -> 9 wrap is legal
        beat(4'b0000);
        check_out("wrap09a", 4'd0, 3'b000, 8'd0);
        beat(4'b1101);
        check_out("wrap09b", 4'd9, 3'b000, 8'd0);

        // Out-of-range first beat
        do_reset();
        beat(4'b1111);
        check_out("range", 4'b1010, 3'b011, 8'd1);

        // Backpressure: one beat held, next beat waits
        do_reset();
        bus_if.out_ready = 1'b0;
        bus_if.in_valid  = 1'b1;
        bus_if.gray_in   = 4'b0000;
        @(posedge clk);
        #1;
        check_eq("bp.first_valid", bus_if.out_valid, 1'b1);
        bus_if.gray_in = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("bp.hold%0d.in_ready", i), bus_if.in_ready, 1'b0);
            check_eq($sformatf("bp.hold%0d.bcd", i), bus_if.bcd_out, 4'd0);
            check_eq($sformatf("bp.hold%0d.valid", i), bus_if.out_valid, 1'b1);
        end
        bus_if.out_ready = 1'b1;
        #1;
        check_eq("bp.release.in_ready", bus_if.in_ready, 1'b1);
        @(posedge clk);
        #1;
        check_out("bp.b1", 4'd1, 3'b000, 8'd0);
        bus_if.gray_in = 4'b0011;
        @(posedge clk);
        #1;
        check_out("bp.b2", 4'd2, 3'b000, 8'd0);
        bus_if.gray_in = 4'b0010;
        @(posedge clk);
        #1;
        check_out("bp.b3", 4'd3, 3'b000, 8'd0);
        bus_if.in_valid = 1'b0;

        // Reset mid-transfer drops the held beat
        bus_if.out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst.valid", bus_if.out_valid, 1'b0);
        check_eq("midrst.bcd", bus_if.bcd_out, 4'd0);
        check_eq("midrst.state", state_dbg, 2'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_if.out_ready = 1'b1;

        // Saturation, then clear together with a fresh beat
        do_reset();
        for (int i = 1; i <= 300; i++) begin
            beat(4'b1111);
            if (i == 254) check_eq("sat.254", err_count, 8'd254);
            if (i == 255) check_eq("sat.255", err_count, 8'd255);
            if (i == 300) check_eq("sat.300", err_count, 8'd255);
        end
        clear_err = 1'b1;
        beat(4'b0001);
        clear_err = 1'b0;
        check_out("satclr", 4'd1, 3'b000, 8'd0);
        check_eq("satclr.state", state_dbg, 2'd1);

        // Repeated code
        do_reset();
        beat(4'b0011);
        check_out("rep.first", 4'd2, 3'b000, 8'd0);
        beat(4'b0011);
`ifdef GRAY_HOLD_ALLOW_EN
        check_out("rep.second", 4'd2, 3'b000, 8'd0);
`else
        check_out("rep.second", 4'd2, 3'b101, 8'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/gray_step_checker.md
GRAY_STEP_CHECKER -- requirements
Module: gray_step_checker

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1 (rising-edge clock); rst input 1 (async active-high reset).
REQ-002 The block SHALL have gray_in input 4: Gray-coded digit from the upstream BCD-to-Gray stage.
REQ-003 The block SHALL have in_valid input 1: gray_in is valid this cycle.
REQ-004 The block SHALL have in_ready output 1: the block accepts a beat this cycle.
REQ-005 The block SHALL have clear_err input 1: single-cycle pulse that clears the fault state and the error count.
REQ-006 The block SHALL have bcd_out output 4: decoded BCD digit.
REQ-007 The block SHALL have out_valid input/output pair: out_valid output 1 (output beat present) and out_ready input 1 (downstream accepts).
REQ-008 The block SHALL have step_err output 1 and range_err output 1: per-beat error flags, qualified by out_valid.
REQ-009 The block SHALL have fault output 1 (sticky error state) and err_count output 8 (saturating error counter).

Function
REQ-010 A beat SHALL be accepted when in_valid and in_ready are both 1; in_ready = !out_valid | out_ready, which gives a single output register with pass-through on pop.
REQ-011 An accepted beat SHALL appear on bcd_out/out_valid on the next rising edge, giving a latency of 1 cycle.
REQ-012 The decode SHALL be b3=g3, b2=b3^g2, b1=b2^g1, b0=b1^g0.
REQ-013 range_err SHALL be 1 when the decoded value is >9; bcd_out still carries the raw decoded value.
REQ-014 The FSM SHALL have three states:
- IDLE: no previous code held.
- TRACK: previous code held.
- FAULT: sticky error, previous code held.
REQ-015 In IDLE, the accepted beat SHALL skip the step check; it stores the previous code and moves to TRACK, or to FAULT if range_err.
REQ-016 In TRACK/FAULT, step_err SHALL be 1 unless the Hamming distance between gray_in and the previous code is exactly 1, or the transition is the 9->0 wrap (1101->0000) or the 0->9 wrap (0000->1101).
REQ-017 The previous code SHALL update on every accepted beat, including erroneous beats.
REQ-018 A beat with any error flag set SHALL move TRACK to FAULT; FAULT is left only via clear_err or rst.
REQ-019 err_count SHALL increment by 1 per accepted beat with step_err|range_err, and SHALL saturate at 255.
REQ-020 clear_err SHALL take priority over acceptance: state goes to IDLE and err_count to 0.
REQ-021 A beat accepted in the same cycle as clear_err SHALL be processed as the first code, with no step check; err_count becomes 1 if that beat has range_err, else 0.
REQ-022 When out_valid=1 and out_ready=0, bcd_out, step_err and range_err SHALL hold stable and in_ready SHALL be 0.
REQ-023 fault SHALL be 1 exactly while the state is FAULT.

Reset
REQ-024 On rst assertion, the block SHALL immediately (asynchronously) set:
- state to IDLE;
- out_valid, step_err, range_err and fault to 0;
- bcd_out to 0000;
- err_count to 0;
- previous code to 0000.
REQ-025 Reset mid-transfer SHALL discard the held output beat.
REQ-026 The first beat after reset SHALL be treated as an IDLE beat.

Configuration
REQ-027 With GRAY_HOLD_ALLOW_EN defined, a repeated code (Hamming distance 0) SHALL NOT raise step_err.
REQ-028 Without GRAY_HOLD_ALLOW_EN, a repeated code SHALL raise step_err.

Verification
REQ-029 Reset, then stream Gray 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101 -> bcd_out 0..9 one cycle after each accept; no flags; fault=0; err_count=0.
REQ-030 Continue the REQ-029 stream with 1101 then 0000 (9->0 wrap) -> no step_err; then 0000->0011 -> step_err=1, fault=1, err_count=1.
REQ-031 Feed 1111 (decodes to 10) as the first beat after reset -> range_err=1, bcd_out=1010, fault=1, err_count=1.
REQ-032 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, output stable, no beat lost; then release -> one beat per cycle.
REQ-033 Force 300 erroneous beats, then pulse clear_err together with gray_in=0001 valid -> err_count saturates at 255, then returns to 0, state is TRACK, and bcd_out=0001 has no flags.
REQ-034 Feed 0011 then 0011 -> step_err=0 with GRAY_HOLD_ALLOW_EN defined, and step_err=1 without it.
